// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: destination zones,
// ALU opcodes, trap causes and the result-register control payload.
package ex_pkg;

  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned CAUSE_W = 4;
  localparam int unsigned REGA_W  = 5;

  typedef enum logic [1:0] {
    ZONE_NONE    = 2'd0,
    ZONE_REGFILE = 2'd1,
    ZONE_LOADQ   = 2'd2,
    ZONE_STOREQ  = 2'd3
  } t_zone;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR   = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLL   = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = 4'd9;
  localparam logic [ALUOP_W-1:0] ALU_PASSB = 4'd10;

  // Misaligned-target traps share code 0 with plain branch redirects.
  localparam logic [CAUSE_W-1:0] CAUSE_BRANCH      = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN    = 4'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_FETCH_FAULT = 4'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL     = 4'd2;

  typedef struct packed {
    logic              valid;
    t_zone             zone;
    logic [REGA_W-1:0] regd;
    logic [2:0]        funct3;
  } t_res_ctl;

endpackage

// File: rtl/exec_unit_if.sv
// Decoder / write-back / hart-vector / load-store-queue bundle of the execute stage.
// master = surrounding pipeline, slave = exec_unit.
interface exec_unit_if #(parameter int unsigned C_XLEN = 32) ();
  import ex_pkg::*;

  logic                ids_dav_i;
  logic                ids_ack_o;
  logic                ids_sofr_i;
  logic                ids_ins_uerr_i;
  logic                ids_ins_ferr_i;
  logic                ids_ins_c_i;
  logic                ids_cond_i;
  logic                ids_link_i;
  t_zone               ids_zone_i;
  logic [C_XLEN-1:0]   ids_pc_i;
  logic [C_XLEN-1:0]   ids_operand_left_i;
  logic [C_XLEN-1:0]   ids_operand_right_i;
  logic [C_XLEN-1:0]   ids_regs1_data_i;
  logic [C_XLEN-1:0]   ids_regs2_data_i;
  logic [ALUOP_W-1:0]  ids_alu_op_i;
  logic [2:0]          ids_funct3_i;
  logic [REGA_W-1:0]   ids_regd_addr_i;

  logic                ids_regd_wr_o;
  logic [REGA_W-1:0]   ids_regd_addr_o;
  logic [C_XLEN-1:0]   ids_regd_data_o;

  logic                hvec_vec_strobe_o;
  logic [C_XLEN-1:0]   hvec_vec_o;
  logic [C_XLEN-1:0]   hvec_pc_o;
  logic [CAUSE_W-1:0]  hvec_cause_o;

  logic                lsq_lq_full_i;
  logic                lsq_sq_full_i;
  logic                lsq_lq_wr_o;
  logic                lsq_sq_wr_o;
  logic [2:0]          lsq_funct3_o;
  logic [REGA_W-1:0]   lsq_regd_addr_o;
  logic [C_XLEN-1:0]   lsq_regs2_data_o;
  logic [C_XLEN-1:0]   lsq_addr_o;

  modport master (
    output ids_dav_i, ids_sofr_i, ids_ins_uerr_i, ids_ins_ferr_i, ids_ins_c_i,
           ids_cond_i, ids_link_i, ids_zone_i, ids_pc_i, ids_operand_left_i,
           ids_operand_right_i, ids_regs1_data_i, ids_regs2_data_i, ids_alu_op_i,
           ids_funct3_i, ids_regd_addr_i, lsq_lq_full_i, lsq_sq_full_i,
    input  ids_ack_o, ids_regd_wr_o, ids_regd_addr_o, ids_regd_data_o,
           hvec_vec_strobe_o, hvec_vec_o, hvec_pc_o, hvec_cause_o,
           lsq_lq_wr_o, lsq_sq_wr_o, lsq_funct3_o, lsq_regd_addr_o,
           lsq_regs2_data_o, lsq_addr_o
  );

  modport slave (
    input  ids_dav_i, ids_sofr_i, ids_ins_uerr_i, ids_ins_ferr_i, ids_ins_c_i,
           ids_cond_i, ids_link_i, ids_zone_i, ids_pc_i, ids_operand_left_i,
           ids_operand_right_i, ids_regs1_data_i, ids_regs2_data_i, ids_alu_op_i,
           ids_funct3_i, ids_regd_addr_i, lsq_lq_full_i, lsq_sq_full_i,
    output ids_ack_o, ids_regd_wr_o, ids_regd_addr_o, ids_regd_data_o,
           hvec_vec_strobe_o, hvec_vec_o, hvec_pc_o, hvec_cause_o,
           lsq_lq_wr_o, lsq_sq_wr_o, lsq_funct3_o, lsq_regd_addr_o,
           lsq_regs2_data_o, lsq_addr_o
  );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU used by the execute stage.
module alu
  import ex_pkg::*;
#(
  parameter int unsigned C_XLEN = 32
) (
  input  logic [ALUOP_W-1:0] op_i,
  input  logic [C_XLEN-1:0]  a_i,
  input  logic [C_XLEN-1:0]  b_i,
  output logic [C_XLEN-1:0]  y_o
);

  localparam int unsigned SHW = $clog2(C_XLEN);

  logic [SHW-1:0] shamt;

  always_comb begin
    y_o   = '0;
    shamt = b_i[SHW-1:0];
    case (op_i)
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_OR:    y_o = a_i | b_i;
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_SLL:   y_o = a_i << shamt;
      ALU_SRL:   y_o = a_i >> shamt;
      ALU_SRA:   y_o = C_XLEN'($signed(a_i) >>> shamt);
      ALU_SLT:   y_o = {{(C_XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:  y_o = {{(C_XLEN-1){1'b0}}, (a_i < b_i)};
      ALU_PASSB: y_o = b_i;
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/branch_cmp.sv
// Conditional-branch comparator: decodes funct3 into a taken flag.
module branch_cmp #(
  parameter int unsigned C_XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [C_XLEN-1:0] a_i,
  input  logic [C_XLEN-1:0] b_i,
  output logic              taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      3'b000:  taken_o = (a_i == b_i);
      3'b001:  taken_o = (a_i != b_i);
      3'b100:  taken_o = ($signed(a_i) <  $signed(b_i));
      3'b101:  taken_o = ($signed(a_i) >= $signed(b_i));
      3'b110:  taken_o = (a_i <  b_i);
      3'b111:  taken_o = (a_i >= b_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU, branch resolution/redirect, trapping, wrong-path kill
// window and a single result register with LSQ backpressure.
module exec_unit
  import ex_pkg::*;
#(
  parameter int unsigned      C_XLEN       = 32,
  parameter bit               C_COMPRESSED = 1'b0,
  parameter logic [C_XLEN-1:0] C_TRAP_BASE = 'h100
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clk_en_i,
  exec_unit_if.slave    bus
);

  logic [C_XLEN-1:0]  alu_y;
  logic               cmp_taken;

  logic [C_XLEN-1:0]  inc;
  logic [C_XLEN-1:0]  link_pc;
  logic [C_XLEN-1:0]  target;
  logic               redirect;
  logic               misalign;
  logic               killed;
  logic               trap;
  logic               fire;
  logic [CAUSE_W-1:0] trap_cause;
  t_res_ctl           ctl_d;
  logic [C_XLEN-1:0]  data_d;
  logic [C_XLEN-1:0]  vec_d;
  logic [CAUSE_W-1:0] cause_d;

  logic               hold;
  logic               ack;

  t_res_ctl           ctl_q;
  logic [C_XLEN-1:0]  data_q;
  logic [C_XLEN-1:0]  addr_q;
  logic [C_XLEN-1:0]  regs2_q;
  logic               kill_q;
  logic               strobe_q;
  logic [C_XLEN-1:0]  vec_q;
  logic [C_XLEN-1:0]  hpc_q;
  logic [CAUSE_W-1:0] cause_q;

  alu #(.C_XLEN(C_XLEN)) u_alu (
    .op_i (bus.ids_alu_op_i),
    .a_i  (bus.ids_operand_left_i),
    .b_i  (bus.ids_operand_right_i),
    .y_o  (alu_y)
  );

  branch_cmp #(.C_XLEN(C_XLEN)) u_branch_cmp (
    .funct3_i (bus.ids_funct3_i),
    .a_i      (bus.ids_regs1_data_i),
    .b_i      (bus.ids_regs2_data_i),
    .taken_o  (cmp_taken)
  );

  // A held LSQ-zoned result blocks the decoder until its queue has room.
  always_comb begin
    hold = ctl_q.valid &
           (((ctl_q.zone == ZONE_LOADQ)  & bus.lsq_lq_full_i) |
            ((ctl_q.zone == ZONE_STOREQ) & bus.lsq_sq_full_i));
    ack  = bus.ids_dav_i & ~hold & clk_en_i;
  end

  // Next result, redirect and trap decision for the instruction on offer.
  always_comb begin
    trap_cause = CAUSE_MISALIGN;
    inc        = (C_COMPRESSED && bus.ids_ins_c_i) ? C_XLEN'(2) : C_XLEN'(4);
    link_pc    = bus.ids_pc_i + inc;
    target     = {alu_y[C_XLEN-1:1], 1'b0};
    redirect   = (bus.ids_cond_i & cmp_taken) | bus.ids_link_i;
    misalign   = redirect & target[1] & ~C_COMPRESSED;
    killed     = kill_q & ~bus.ids_sofr_i;
    trap       = ~killed & (bus.ids_ins_ferr_i | bus.ids_ins_uerr_i | misalign);
    fire       = ~killed & (trap | redirect);

    if (bus.ids_ins_ferr_i)      trap_cause = CAUSE_FETCH_FAULT;
    else if (bus.ids_ins_uerr_i) trap_cause = CAUSE_ILLEGAL;

    ctl_d.valid  = 1'b1;
    ctl_d.zone   = (killed | trap) ? ZONE_NONE : bus.ids_zone_i;
    ctl_d.regd   = bus.ids_regd_addr_i;
    ctl_d.funct3 = bus.ids_funct3_i;
    data_d       = bus.ids_link_i ? link_pc : alu_y;
    vec_d        = trap ? C_TRAP_BASE : target;
    cause_d      = trap ? trap_cause : CAUSE_BRANCH;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctl_q    <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      regs2_q  <= '0;
      kill_q   <= 1'b0;
      strobe_q <= 1'b0;
      vec_q    <= '0;
      hpc_q    <= '0;
      cause_q  <= '0;
    end else if (clk_en_i) begin
      strobe_q <= ack & fire;
      if (ack) begin
        ctl_q   <= ctl_d;
        data_q  <= data_d;
        addr_q  <= alu_y;
        regs2_q <= bus.ids_regs2_data_i;
        // A new redirect re-opens the window even if this one carried sofr.
        kill_q  <= fire | (kill_q & ~bus.ids_sofr_i);
        if (fire) begin
          vec_q   <= vec_d;
          hpc_q   <= bus.ids_pc_i;
          cause_q <= cause_d;
        end
      end else if (!hold) begin
        ctl_q.valid <= 1'b0;
      end
    end
  end

  assign bus.ids_ack_o         = ack;
  assign bus.ids_regd_wr_o     = clk_en_i & ctl_q.valid & (ctl_q.zone == ZONE_REGFILE);
  assign bus.ids_regd_addr_o   = ctl_q.regd;
  assign bus.ids_regd_data_o   = data_q;
  assign bus.lsq_lq_wr_o       = clk_en_i & ctl_q.valid & (ctl_q.zone == ZONE_LOADQ) &
                                 ~bus.lsq_lq_full_i;
  assign bus.lsq_sq_wr_o       = clk_en_i & ctl_q.valid & (ctl_q.zone == ZONE_STOREQ) &
                                 ~bus.lsq_sq_full_i;
  assign bus.lsq_funct3_o      = ctl_q.funct3;
  assign bus.lsq_regd_addr_o   = ctl_q.regd;
  assign bus.lsq_regs2_data_o  = regs2_q;
  assign bus.lsq_addr_o        = addr_q;
  assign bus.hvec_vec_strobe_o = strobe_q & clk_en_i;
  assign bus.hvec_vec_o        = vec_q;
  assign bus.hvec_pc_o         = hpc_q;
  assign bus.hvec_cause_o      = cause_q;

endmodule
